alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares the single registered ALU datapath between two requesters: port 0 is the execute stage and port 1 is the branch-compare/address-gen unit. The block arbitrates round-robin, registers the granted operation onto the ALU inputs and tracks in-flight operations with a tag pipeline. It returns each result to its owner with a one-cycle valid strobe. It sits between the decode/issue logic and the wrapped ALU, and supports a pipeline flush of port-0 work.

Parameters:
ALU_LAT, 2, cycles from ALU inputs being driven (issue register valid) to alu_res being valid; must be >= 1
XLEN, 32, datapath width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active high
req0_valid  in  1  port 0 request
req0_ready  out  1  port 0 grant (combinational)
req0_rs1  in  XLEN  operand 1
req0_rs2  in  XLEN  register operand 2
req0_imm  in  XLEN  immediate operand 2
req0_ctl  in  6  {use_imm, op[2:0], mod, operand_2_neg}
req1_valid / req1_ready / req1_rs1 / req1_rs2 / req1_imm / req1_ctl  same as port 0, for port 1
flush0  in  1  kill all accepted/in-flight port-0 operations
alu_rs1_val  out  XLEN  to ALU
alu_rs2_val  out  XLEN  to ALU
alu_imm  out  XLEN  to ALU
alu_use_imm  out  1  to ALU
alu_op  out  3  to ALU
alu_mod  out  1  to ALU
alu_operand_2_neg  out  1  to ALU
alu_res  in  XLEN  ALU result
resp0_valid  out  1  result for port 0 (single-cycle strobe)
resp1_valid  out  1  result for port 1 (single-cycle strobe)
resp_res  out  XLEN  result, qualified by resp0_valid or resp1_valid

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: issue registers and ALU-driving outputs all 0. Tag pipeline all invalid. resp0_valid = resp1_valid = 0. Round-robin pointer = 0, so port 0 wins the first tie.
- Arbitration (combinational, one grant per cycle):
  - Only one port valid: that port gets ready=1.
  - Both valid: the port named by the pointer is granted.
  - After any grant, the pointer moves to the non-granted port.
  - No grant: the pointer holds.
  - req0_ready is forced to 0 while flush0=1 or rst=1. req1_ready is forced to 0 while rst=1.
- Handshake: a transfer occurs when valid & ready in the same cycle. Requesters hold their payload until ready.
- Issue stage: on a transfer at edge N, the payload is latched into the issue registers, which drive the alu_* outputs from cycle N+1. With no transfer, the issue registers hold their last payload and the issue-valid bit is cleared.
- Tag pipeline: depth ALU_LAT+1. Each entry is {valid, owner}. An entry enters at the transfer edge and shifts every cycle; there are no stalls and no response backpressure.
- Response: issued exactly ALU_LAT+1 cycles after the transfer cycle.
  - The resp strobe for the tail entry's owner is asserted only if the entry is valid.
  - resp_res = alu_res sampled that cycle, combinational pass-through.
- Throughput: one operation per cycle total, so back-to-back grants are legal.
- flush0: in the flush cycle, every valid tag entry with owner 0 is cleared, including the entry being issued. Port-1 entries are untouched.
  - A port-0 response due in the flush cycle is suppressed.
  - Port 1 may still be granted during flush0.
- Reset mid-operation: all in-flight tags are discarded and no response is emitted after reset. Outputs follow the reset values from the next cycle.
- Simultaneous flush0 and port-1 response: the port-1 response is delivered normally.

Decomposition:
- Shared package holds: the ALU op encodings (3-bit), the ctl field bit positions (USE_IMM=5, OP=4:2, MOD=1, NEG=0), and the owner encoding (PORT_EXE=0, PORT_BR=1).
- One natural sub-module, rr_arbiter2: a 2-way round-robin arbiter with a pointer register, inputs valid[1:0], output grant[1:0].
- The tag pipeline stays in the top module.

Test Plan:
- Single op, port 0 (ALU_LAT=2): add with rs1=5, rs2=7, ctl use_imm=0, transfer at cycle 3.
  - Required: alu_rs1_val=5 from cycle 4; resp0_valid=1 with resp_res=12 only at cycle 6; resp1_valid stays 0.
- Tie: both valid continuously for 4 cycles right after reset.
  - Required: grants go 0,1,0,1; responses return in the same order at a one-per-cycle rate.
- Immediate with negate, port 1: rs1=10, imm=3, use_imm=1, neg=1, op=add.
  - Required: resp1_valid with resp_res=7.
- Flush: port-0 op accepted at cycle 3, then port-1 op at cycle 4, then flush0=1 at cycle 5.
  - Required: no resp0_valid at cycle 6; resp1_valid at cycle 7; req0_ready=0 during cycle 5.
- Reset mid-flight: two ops accepted, then rst=1 for 1 cycle before either completes.
  - Required: no response strobes afterward; pointer back to 0; alu_* outputs read 0.
- Back-to-back port 0 only, 8 consecutive ops with varying rs1.
  - Required: req0_ready is held high throughout; 8 consecutive resp0_valid pulses carry the correct results.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_share_arbiter_pkg: shared encodings for the ALU share arbiter  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package alu_share_arbiter_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SLL  = 3'd1,
    ALU_SLT  = 3'd2,
    ALU_SLTU = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SR   = 3'd5,
    ALU_OR   = 3'd6,
    ALU_AND  = 3'd7
  } alu_op_e;

  localparam int CTL_W       = 6;
  localparam int CTL_USE_IMM = 5;
  localparam int CTL_OP_HI   = 4;
  localparam int CTL_OP_LO   = 2;
  localparam int CTL_MOD     = 1;
  localparam int CTL_NEG     = 0;

  typedef enum logic {
    PORT_EXE = 1'b0,
    PORT_BR  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter2: two-way round-robin arbiter, one grant per cycle      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  // ptr names the port that wins the next tie
  logic ptr;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (grant[0]) begin
      ptr <= 1'b1;
    end else if (grant[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_share_arbiter: shares one registered ALU between two ports     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module alu_share_arbiter #(
  parameter int ALU_LAT = 2,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_rs1,
  input  logic [XLEN-1:0] req0_rs2,
  input  logic [XLEN-1:0] req0_imm,
  input  logic [5:0]      req0_ctl,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_rs1,
  input  logic [XLEN-1:0] req1_rs2,
  input  logic [XLEN-1:0] req1_imm,
  input  logic [5:0]      req1_ctl,
  input  logic            flush0,
  output logic [XLEN-1:0] alu_rs1_val,
  output logic [XLEN-1:0] alu_rs2_val,
  output logic [XLEN-1:0] alu_imm,
  output logic            alu_use_imm,
  output logic [2:0]      alu_op,
  output logic            alu_mod,
  output logic            alu_operand_2_neg,
  input  logic [XLEN-1:0] alu_res,
  output logic            resp0_valid,
  output logic            resp1_valid,
  output logic [XLEN-1:0] resp_res
);

  import alu_share_arbiter_pkg::*;

  logic [1:0]        req_valid;
  logic [1:0]        grant;
  logic              xfer;
  logic [XLEN-1:0]   iss_rs1;
  logic [XLEN-1:0]   iss_rs2;
  logic [XLEN-1:0]   iss_imm;
  logic [CTL_W-1:0]  iss_ctl;
  tag_t              tags [ALU_LAT+1];
  tag_t              tail;

  assign req_valid = {req1_valid & ~rst, req0_valid & ~flush0 & ~rst};

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (req_valid),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign xfer       = |grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_rs1 <= '0;
      iss_rs2 <= '0;
      iss_imm <= '0;
      iss_ctl <= '0;
    end else if (xfer) begin
      iss_rs1 <= grant[1] ? req1_rs1 : req0_rs1;
      iss_rs2 <= grant[1] ? req1_rs2 : req0_rs2;
      iss_imm <= grant[1] ? req1_imm : req0_imm;
      iss_ctl <= grant[1] ? req1_ctl : req0_ctl;
    end
  end

  assign alu_rs1_val       = iss_rs1;
  assign alu_rs2_val       = iss_rs2;
  assign alu_imm           = iss_imm;
  assign alu_use_imm       = iss_ctl[CTL_USE_IMM];
  assign alu_op            = iss_ctl[CTL_OP_HI:CTL_OP_LO];
  assign alu_mod           = iss_ctl[CTL_MOD];
  assign alu_operand_2_neg = iss_ctl[CTL_NEG];

  // tags[0] doubles as the issue-valid bit; a flush kills port-0 entries as they shift
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= ALU_LAT; i++) begin
        tags[i] <= '0;
      end
    end else begin
      tags[0].valid <= xfer;
      tags[0].owner <= grant[1] ? PORT_BR : PORT_EXE;
      for (int i = 1; i <= ALU_LAT; i++) begin
        tags[i].valid <= tags[i-1].valid & ~(flush0 & (tags[i-1].owner == PORT_EXE));
        tags[i].owner <= tags[i-1].owner;
      end
    end
  end

  assign tail        = tags[ALU_LAT];
  assign resp0_valid = tail.valid & (tail.owner == PORT_EXE) & ~flush0 & ~rst;
  assign resp1_valid = tail.valid & (tail.owner == PORT_BR) & ~rst;
  assign resp_res    = alu_res;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_share_arbiter: randomized scoreboard bench for the arbiter  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int ALU_LAT = 2;
  localparam int XLEN    = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [XLEN-1:0] req0_rs1, req0_rs2, req0_imm, req1_rs1, req1_rs2, req1_imm;
  logic [5:0]      req0_ctl, req1_ctl;
  logic            flush0;
  logic [XLEN-1:0] alu_rs1_val, alu_rs2_val, alu_imm, alu_res, resp_res;
  logic            alu_use_imm, alu_mod, alu_operand_2_neg;
  logic [2:0]      alu_op;
  logic            resp0_valid, resp1_valid;

  always #5 clk = ~clk;

  alu_share_arbiter #(.ALU_LAT(ALU_LAT), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs1(req0_rs1),
    .req0_rs2(req0_rs2), .req0_imm(req0_imm), .req0_ctl(req0_ctl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs1(req1_rs1),
    .req1_rs2(req1_rs2), .req1_imm(req1_imm), .req1_ctl(req1_ctl),
    .flush0(flush0),
    .alu_rs1_val(alu_rs1_val), .alu_rs2_val(alu_rs2_val), .alu_imm(alu_imm),
    .alu_use_imm(alu_use_imm), .alu_op(alu_op), .alu_mod(alu_mod),
    .alu_operand_2_neg(alu_operand_2_neg), .alu_res(alu_res),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_res(resp_res)
  );

  // Behavioural ALU: result as a function of the operation fields
  function automatic logic [XLEN-1:0] alu_f(input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                                            input logic [XLEN-1:0] imm, input logic [5:0] ctl);
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] r;
    op2 = ctl[CTL_USE_IMM] ? imm : rs2;
    if (ctl[CTL_NEG]) op2 = -op2;
    case (ctl[CTL_OP_HI:CTL_OP_LO])
      3'd0:    r = ctl[CTL_MOD] ? rs1 - op2 : rs1 + op2;
      3'd1:    r = rs1 << op2[4:0];
      3'd2:    r = ($signed(rs1) < $signed(op2)) ? 1 : 0;
      3'd3:    r = (rs1 < op2) ? 1 : 0;
      3'd4:    r = rs1 ^ op2;
      3'd5:    r = ctl[CTL_MOD] ? XLEN'($signed(rs1) >>> op2[4:0]) : rs1 >> op2[4:0];
      3'd6:    r = rs1 | op2;
      default: r = rs1 & op2;
    endcase
    return r;
  endfunction

  logic [XLEN-1:0] alu_pipe [ALU_LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_f(alu_rs1_val, alu_rs2_val, alu_imm,
                         {alu_use_imm, alu_op, alu_mod, alu_operand_2_neg});
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_res = alu_pipe[ALU_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic            owner;
    logic [XLEN-1:0] res;
    int              due;
  } exp_t;
  exp_t sbq[$];

  int  checks = 0;
  int  passes = 0;
  bit  prefer = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    else passes++;
  endtask

  task automatic rand0();
    req0_rs1 = $urandom(); req0_rs2 = $urandom(); req0_imm = $urandom(); req0_ctl = 6'($urandom());
  endtask

  task automatic rand1();
    req1_rs1 = $urandom(); req1_rs2 = $urandom(); req1_imm = $urandom(); req1_ctl = 6'($urandom());
  endtask

  // One cycle: predict grants, check ready, record expected responses, advance past the edge
  task automatic tick(output bit g0, output bit g1);
    bit v0, v1;
    exp_t e;
    @(negedge clk);
    v0 = req0_valid && !flush0 && !rst;
    v1 = req1_valid && !rst;
    if (v0 && v1) begin
      g0 = (prefer == 1'b0);
      g1 = !g0;
    end else begin
      g0 = v0;
      g1 = v1;
    end
    check("req0_ready", req0_ready, g0);
    check("req1_ready", req1_ready, g1);
    if (flush0 && !rst) begin
      exp_t keep[$];
      foreach (sbq[i]) if (sbq[i].owner) keep.push_back(sbq[i]);
      sbq = keep;
    end
    if (g0) begin
      e.owner = 1'b0; e.res = alu_f(req0_rs1, req0_rs2, req0_imm, req0_ctl);
      e.due = cyc + ALU_LAT + 1; sbq.push_back(e);
      prefer = 1'b1;
    end
    if (g1) begin
      e.owner = 1'b1; e.res = alu_f(req1_rs1, req1_rs2, req1_imm, req1_ctl);
      e.due = cyc + ALU_LAT + 1; sbq.push_back(e);
      prefer = 1'b0;
    end
    if (rst) begin
      sbq.delete();
      prefer = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every non-reset cycle, compare response strobes against the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
          check("resp0_valid", resp0_valid, !sbq[0].owner);
          check("resp1_valid", resp1_valid, sbq[0].owner);
          check("resp_res", resp_res, sbq[0].res);
          void'(sbq.pop_front());
        end else begin
          check("resp0_valid", resp0_valid, 1'b0);
          check("resp1_valid", resp1_valid, 1'b0);
        end
      end
    end
  end

  task automatic idle(input int n);
    bit g0, g1;
    req0_valid = 1'b0; req1_valid = 1'b0; flush0 = 1'b0;
    for (int i = 0; i < n; i++) tick(g0, g1);
  endtask

  task automatic check_alu_zero(input string name);
    check(name, {alu_rs1_val, alu_rs2_val}, 64'd0);
    check(name, {alu_imm, 26'd0, alu_use_imm, alu_op, alu_mod, alu_operand_2_neg}, 64'd0);
  endtask

  initial begin
    bit g0, g1, p0, p1;
    rst = 1'b1; flush0 = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    rand0(); rand1();
    tick(g0, g1);
    tick(g0, g1);
    check_alu_zero("reset_alu");
    check("reset_resp", {resp0_valid, resp1_valid}, 2'b00);
    rst = 1'b0;
    idle(1);

    // single add on port 0
    req0_valid = 1'b1; req0_rs1 = 5; req0_rs2 = 7; req0_imm = 99; req0_ctl = {1'b0, ALU_ADD, 1'b0, 1'b0};
    tick(g0, g1);
    req0_valid = 1'b0;
    check("issue_rs1", alu_rs1_val, 5);
    idle(ALU_LAT + 2);

    // tie: both valid for four cycles
    req0_valid = 1'b1; req1_valid = 1'b1; rand0(); rand1();
    for (int i = 0; i < 4; i++) begin
      tick(g0, g1);
      if (g0) rand0();
      if (g1) rand1();
    end
    idle(ALU_LAT + 2);

    // immediate with negate on port 1: 10 + (-3)
    req1_valid = 1'b1; req1_rs1 = 10; req1_rs2 = 1234; req1_imm = 3; req1_ctl = {1'b1, ALU_ADD, 1'b0, 1'b1};
    tick(g0, g1);
    idle(ALU_LAT + 2);

    // flush: port-0 op, port-1 op, then flush while port 0 requests again
    req0_valid = 1'b1; rand0();
    tick(g0, g1);
    req0_valid = 1'b0; req1_valid = 1'b1; rand1();
    tick(g0, g1);
    req1_valid = 1'b0; req0_valid = 1'b1; rand0(); flush0 = 1'b1;
    tick(g0, g1);
    flush0 = 1'b0;
    tick(g0, g1);
    idle(ALU_LAT + 2);

    // reset mid-flight, last grant to port 0 so the pointer must return to 0
    req1_valid = 1'b1; rand1();
    tick(g0, g1);
    req1_valid = 1'b0; req0_valid = 1'b1; rand0();
    tick(g0, g1);
    req0_valid = 1'b0; rst = 1'b1;
    tick(g0, g1);
    rst = 1'b0;
    check_alu_zero("post_reset_alu");
    req0_valid = 1'b1; req1_valid = 1'b1; rand0(); rand1();
    tick(g0, g1);
    idle(ALU_LAT + 2);

    // back-to-back port 0
    req0_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand0(); req0_ctl = {1'b0, ALU_ADD, 1'b0, 1'b0};
      tick(g0, g1);
    end
    idle(ALU_LAT + 2);

    // randomized traffic with occasional flush and reset
    p0 = 1'b0; p1 = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!p0) begin req0_valid = ($urandom_range(0, 9) < 6); rand0(); end
      if (!p1) begin req1_valid = ($urandom_range(0, 9) < 6); rand1(); end
      flush0 = ($urandom_range(0, 15) == 0);
      rst    = ($urandom_range(0, 149) == 0);
      tick(g0, g1);
      p0 = req0_valid && !g0 && !rst;
      p1 = req1_valid && !g1 && !rst;
    end
    rst = 1'b0;
    idle(ALU_LAT + 3);
    check("scoreboard_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
